// File: rtl/dr_mem_sched.sv
// dr_mem_sched: directory-bank memory-side scheduler.
//
// Merges three directory-to-memory streams onto one registered memory request
// channel:
//   - demand requests   (req_*)   : id + command + address
//   - writebacks        (wb_*)    : full line + address
//   - L2 prefetches     (pfreq_*) : node id + address, buffered in a small
//                                   drop-oldest circular queue
//
// Handshake (all channels): a transfer happens in a cycle where valid is high
// and retry is low. While valid is high and retry is high the sender holds
// its payload stable.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   req_valid/req_retry   demand request channel (req_drid, req_cmd, req_paddr)
//   wb_valid/wb_retry     writeback channel (wb_line, wb_paddr)
//   pfreq_valid/pfreq_retry prefetch channel (pfreq_nid, pfreq_paddr);
//                         pfreq_retry is tied low, overflow drops the oldest
//   mem_valid/mem_retry   registered memory channel; mem_kind 0=req 1=wb 2=pf,
//                         fields not belonging to the kind are zero
//   pf_drop_cnt           saturating count of prefetches lost to overflow
//
// The output register is a two-state machine (EMPTY/FULL); its state is
// visible directly on mem_valid.
module dr_mem_sched #(
  parameter int PADDR_W   = 50,
  parameter int DRID_W    = 6,
  parameter int CMD_W     = 3,
  parameter int NID_W     = 5,
  parameter int LINE_W    = 512,
  parameter int PF_DEPTH  = 8,
  parameter int WB_STARVE = 4,
  parameter int PF_STARVE = 16
) (
  input  logic               clk,
  input  logic               reset,
  // demand requests
  input  logic               req_valid,
  output logic               req_retry,
  input  logic [DRID_W-1:0]  req_drid,
  input  logic [CMD_W-1:0]   req_cmd,
  input  logic [PADDR_W-1:0] req_paddr,
  // writebacks
  input  logic               wb_valid,
  output logic               wb_retry,
  input  logic [LINE_W-1:0]  wb_line,
  input  logic [PADDR_W-1:0] wb_paddr,
  // prefetches
  input  logic               pfreq_valid,
  output logic               pfreq_retry,
  input  logic [NID_W-1:0]   pfreq_nid,
  input  logic [PADDR_W-1:0] pfreq_paddr,
  // memory channel
  output logic               mem_valid,
  input  logic               mem_retry,
  output logic [1:0]         mem_kind,
  output logic [DRID_W-1:0]  mem_drid,
  output logic [CMD_W-1:0]   mem_cmd,
  output logic [NID_W-1:0]   mem_nid,
  output logic [PADDR_W-1:0] mem_paddr,
  output logic [LINE_W-1:0]  mem_line,
  output logic [15:0]        pf_drop_cnt
);

  localparam int PTR_W = $clog2(PF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] PF_FULL = CNT_W'(PF_DEPTH);
  localparam logic [3:0]       WB_LIM  = 4'(WB_STARVE);
  localparam logic [4:0]       PF_LIM  = 5'(PF_STARVE);

  localparam logic [1:0] KIND_REQ = 2'd0;
  localparam logic [1:0] KIND_WB  = 2'd1;
  localparam logic [1:0] KIND_PF  = 2'd2;

  // Output register states
  localparam logic OUT_EMPTY = 1'b0;
  localparam logic OUT_FULL  = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                out_state_q, out_state_d;
  logic [1:0]          mem_kind_q;
  logic [DRID_W-1:0]   mem_drid_q;
  logic [CMD_W-1:0]    mem_cmd_q;
  logic [NID_W-1:0]    mem_nid_q;
  logic [PADDR_W-1:0]  mem_paddr_q;
  logic [LINE_W-1:0]   mem_line_q;

  logic [PTR_W-1:0]    pf_head_q, pf_head_d;
  logic [PTR_W-1:0]    pf_tail_q, pf_tail_d;
  logic [CNT_W-1:0]    pf_cnt_q, pf_cnt_d;
  logic [PF_DEPTH-1:0] pf_vld_q, pf_vld_d;
  logic [NID_W-1:0]    pf_nid_q   [PF_DEPTH];
  logic [PADDR_W-1:0]  pf_paddr_q [PF_DEPTH];

  logic [3:0]          wb_age_q, wb_age_d;
  logic [4:0]          pf_age_q, pf_age_d;
  logic [15:0]         pf_drop_q, pf_drop_d;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
  logic load_ok;
  logic head_valid;
  logic head_stale;
  logic wb_same_line;
  logic gnt_req, gnt_wb, gnt_pf;
  logic out_load;

  always_comb begin
    // FULL-and-draining counts as free, giving back-to-back issue.
    load_ok      = (out_state_q == OUT_EMPTY) || !mem_retry;
    head_valid   = (pf_cnt_q != '0) && pf_vld_q[pf_head_q];
    head_stale   = (pf_cnt_q != '0) && !pf_vld_q[pf_head_q];
    // A demand read must not overtake a writeback to the same line.
    wb_same_line = wb_valid &&
                   (wb_paddr[PADDR_W-1:6] == req_paddr[PADDR_W-1:6]);

    gnt_req = 1'b0;
    gnt_wb  = 1'b0;
    gnt_pf  = 1'b0;
    if (load_ok) begin
      if (wb_valid && (wb_age_q >= WB_LIM)) begin
        gnt_wb = 1'b1;
      end else if (head_valid && (pf_age_q >= PF_LIM)) begin
        gnt_pf = 1'b1;
      end else if (req_valid && !wb_same_line) begin
        gnt_req = 1'b1;
      end else if (wb_valid) begin
        gnt_wb = 1'b1;
      end else if (head_valid) begin
        gnt_pf = 1'b1;
      end
    end
    out_load = gnt_req || gnt_wb || gnt_pf;
  end

  // Retries are forced high while reset is held, whatever the grant logic says.
  assign req_retry   = !(reset && gnt_req);
  assign wb_retry    = !(reset && gnt_wb);
  assign pfreq_retry = 1'b0;

  // ---------------------------------------------------------------------------
  // Output register next state and payload mux
  // ---------------------------------------------------------------------------
  logic [1:0]         ld_kind;
  logic [DRID_W-1:0]  ld_drid;
  logic [CMD_W-1:0]   ld_cmd;
  logic [NID_W-1:0]   ld_nid;
  logic [PADDR_W-1:0] ld_paddr;
  logic [LINE_W-1:0]  ld_line;

  always_comb begin
    out_state_d = out_state_q;
    if (out_load) begin
      out_state_d = OUT_FULL;
    end else if ((out_state_q == OUT_FULL) && !mem_retry) begin
      out_state_d = OUT_EMPTY;
    end

    ld_kind  = KIND_REQ;
    ld_drid  = '0;
    ld_cmd   = '0;
    ld_nid   = '0;
    ld_paddr = '0;
    ld_line  = '0;
    if (gnt_req) begin
      ld_kind  = KIND_REQ;
      ld_drid  = req_drid;
      ld_cmd   = req_cmd;
      ld_paddr = req_paddr;
    end else if (gnt_wb) begin
      ld_kind  = KIND_WB;
      ld_paddr = wb_paddr;
      ld_line  = wb_line;
    end else if (gnt_pf) begin
      ld_kind  = KIND_PF;
      ld_nid   = pf_nid_q[pf_head_q];
      ld_paddr = pf_paddr_q[pf_head_q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state_q <= OUT_EMPTY;
      mem_kind_q  <= '0;
      mem_drid_q  <= '0;
      mem_cmd_q   <= '0;
      mem_nid_q   <= '0;
      mem_paddr_q <= '0;
      mem_line_q  <= '0;
    end else begin
      out_state_q <= out_state_d;
      if (out_load) begin
        mem_kind_q  <= ld_kind;
        mem_drid_q  <= ld_drid;
        mem_cmd_q   <= ld_cmd;
        mem_nid_q   <= ld_nid;
        mem_paddr_q <= ld_paddr;
        mem_line_q  <= ld_line;
      end
    end
  end

  assign mem_valid   = out_state_q;
  assign mem_kind    = mem_kind_q;
  assign mem_drid    = mem_drid_q;
  assign mem_cmd     = mem_cmd_q;
  assign mem_nid     = mem_nid_q;
  assign mem_paddr   = mem_paddr_q;
  assign mem_line    = mem_line_q;
  assign pf_drop_cnt = pf_drop_q;

  // ---------------------------------------------------------------------------
  // Prefetch queue
  // ---------------------------------------------------------------------------
  logic pf_push;
  logic pf_pop;
  logic pf_drop;
  logic pf_adv_head;
  logic push_squash;

  always_comb begin
    pf_push     = pfreq_valid;
    // Squashed entries at the head are retired without a grant.
    pf_pop      = gnt_pf || head_stale;
    // A push into a full queue with no pop evicts the oldest entry.
    pf_drop     = pf_push && (pf_cnt_q == PF_FULL) && !pf_pop;
    pf_adv_head = pf_pop || pf_drop;
    push_squash = gnt_req &&
                  (pfreq_paddr[PADDR_W-1:6] == req_paddr[PADDR_W-1:6]);

    pf_head_d = pf_adv_head ? pf_head_q + PTR_W'(1) : pf_head_q;
    pf_tail_d = pf_push     ? pf_tail_q + PTR_W'(1) : pf_tail_q;
    pf_cnt_d  = pf_cnt_q + CNT_W'(pf_push) - CNT_W'(pf_adv_head);

    // A granted demand request makes any queued prefetch of the same line
    // redundant. Unoccupied slots may be cleared too; a push rewrites the bit.
    pf_vld_d = pf_vld_q;
    if (gnt_req) begin
      for (int i = 0; i < PF_DEPTH; i++) begin
        if (pf_paddr_q[i][PADDR_W-1:6] == req_paddr[PADDR_W-1:6]) begin
          pf_vld_d[i] = 1'b0;
        end
      end
    end
    // When full, tail equals head, so this write also overwrites the evicted
    // or popped head slot.
    if (pf_push) begin
      pf_vld_d[pf_tail_q] = !push_squash;
    end

    pf_drop_d = (pf_drop && (pf_drop_q != 16'hFFFF)) ? pf_drop_q + 16'd1
                                                     : pf_drop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pf_head_q <= '0;
      pf_tail_q <= '0;
      pf_cnt_q  <= '0;
      pf_vld_q  <= '0;
      pf_drop_q <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        pf_nid_q[i]   <= '0;
        pf_paddr_q[i] <= '0;
      end
    end else begin
      pf_head_q <= pf_head_d;
      pf_tail_q <= pf_tail_d;
      pf_cnt_q  <= pf_cnt_d;
      pf_vld_q  <= pf_vld_d;
      pf_drop_q <= pf_drop_d;
      if (pf_push) begin
        pf_nid_q[pf_tail_q]   <= pfreq_nid;
        pf_paddr_q[pf_tail_q] <= pfreq_paddr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Anti-starvation age counters
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!wb_valid || gnt_wb) begin
      wb_age_d = '0;
    end else if (wb_age_q != 4'hF) begin
      wb_age_d = wb_age_q + 4'd1;
    end else begin
      wb_age_d = wb_age_q;
    end

    // The age follows the head entry: whenever the head moves (grant, silent
    // retire or eviction) the new head starts from zero.
    if (pf_adv_head) begin
      pf_age_d = '0;
    end else if (head_valid && !gnt_pf && (pf_age_q != 5'h1F)) begin
      pf_age_d = pf_age_q + 5'd1;
    end else begin
      pf_age_d = pf_age_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_age_q <= '0;
      pf_age_q <= '0;
    end else begin
      wb_age_q <= wb_age_d;
      pf_age_q <= pf_age_d;
    end
  end

endmodule

// File: tb/tb_dr_mem_sched.sv
// Testbench for dr_mem_sched: directed scenarios with literal expectations
// followed by protocol-respecting random traffic, all checked every cycle
// against a queue-based behavioural model.
module tb_dr_mem_sched;

  localparam int PADDR_W   = 50;
  localparam int DRID_W    = 6;
  localparam int CMD_W     = 3;
  localparam int NID_W     = 5;
  localparam int LINE_W    = 512;
  localparam int PF_DEPTH  = 8;
  localparam int WB_STARVE = 4;
  localparam int PF_STARVE = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic               req_valid, req_retry;
  logic [DRID_W-1:0]  req_drid;
  logic [CMD_W-1:0]   req_cmd;
  logic [PADDR_W-1:0] req_paddr;
  logic               wb_valid, wb_retry;
  logic [LINE_W-1:0]  wb_line;
  logic [PADDR_W-1:0] wb_paddr;
  logic               pfreq_valid, pfreq_retry;
  logic [NID_W-1:0]   pfreq_nid;
  logic [PADDR_W-1:0] pfreq_paddr;
  logic               mem_valid, mem_retry;
  logic [1:0]         mem_kind;
  logic [DRID_W-1:0]  mem_drid;
  logic [CMD_W-1:0]   mem_cmd;
  logic [NID_W-1:0]   mem_nid;
  logic [PADDR_W-1:0] mem_paddr;
  logic [LINE_W-1:0]  mem_line;
  logic [15:0]        pf_drop_cnt;

  dr_mem_sched #(
    .PADDR_W(PADDR_W), .DRID_W(DRID_W), .CMD_W(CMD_W), .NID_W(NID_W),
    .LINE_W(LINE_W), .PF_DEPTH(PF_DEPTH), .WB_STARVE(WB_STARVE),
    .PF_STARVE(PF_STARVE)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_retry(req_retry), .req_drid(req_drid),
    .req_cmd(req_cmd), .req_paddr(req_paddr),
    .wb_valid(wb_valid), .wb_retry(wb_retry), .wb_line(wb_line),
    .wb_paddr(wb_paddr),
    .pfreq_valid(pfreq_valid), .pfreq_retry(pfreq_retry),
    .pfreq_nid(pfreq_nid), .pfreq_paddr(pfreq_paddr),
    .mem_valid(mem_valid), .mem_retry(mem_retry), .mem_kind(mem_kind),
    .mem_drid(mem_drid), .mem_cmd(mem_cmd), .mem_nid(mem_nid),
    .mem_paddr(mem_paddr), .mem_line(mem_line), .pf_drop_cnt(pf_drop_cnt)
  );

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PADDR_W-1:0] line_of(input logic [PADDR_W-1:0] a);
    return a >> 6;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: output slot, prefetch queue as an SV queue, ages as ints
  // ---------------------------------------------------------------------------
  typedef struct {
    logic               v;
    logic [NID_W-1:0]   nid;
    logic [PADDR_W-1:0] paddr;
  } pf_t;

  pf_t                pfq[$];
  logic               m_full;
  logic [1:0]         m_kind;
  logic [DRID_W-1:0]  m_drid;
  logic [CMD_W-1:0]   m_cmd;
  logic [NID_W-1:0]   m_nid;
  logic [PADDR_W-1:0] m_paddr;
  logic [LINE_W-1:0]  m_line;
  int                 m_wb_age, m_pf_age, m_drop;

  // grant codes used only inside the model: 0 none, 1 req, 2 wb, 3 pf
  int   g;
  bit   load_ok, head_v, pop, dropped;
  pf_t  e;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_mem_valid", 64'(mem_valid), 64'd0);
      chk("rst_req_retry", 64'(req_retry), 64'd1);
      chk("rst_wb_retry", 64'(wb_retry), 64'd1);
      chk("rst_drop_cnt", 64'(pf_drop_cnt), 64'd0);
      pfq.delete();
      m_full = 1'b0; m_wb_age = 0; m_pf_age = 0; m_drop = 0;
    end else begin
      chk("mem_valid", 64'(mem_valid), 64'(m_full));
      if (m_full) begin
        chk("mem_kind", 64'(mem_kind), 64'(m_kind));
        chk("mem_drid", 64'(mem_drid), 64'(m_drid));
        chk("mem_cmd", 64'(mem_cmd), 64'(m_cmd));
        chk("mem_nid", 64'(mem_nid), 64'(m_nid));
        chk("mem_paddr", 64'(mem_paddr), 64'(m_paddr));
        chk_line("mem_line", mem_line, m_line);
      end
      chk("pf_drop_cnt", 64'(pf_drop_cnt), 64'(m_drop));

      load_ok = !m_full || !mem_retry;
      head_v  = (pfq.size() > 0) && pfq[0].v;
      g = 0;
      if (load_ok) begin
        if (wb_valid && m_wb_age >= WB_STARVE) g = 2;
        else if (head_v && m_pf_age >= PF_STARVE) g = 3;
        else if (req_valid && !(wb_valid && line_of(wb_paddr) == line_of(req_paddr))) g = 1;
        else if (wb_valid) g = 2;
        else if (head_v) g = 3;
      end
      chk("req_retry", 64'(req_retry), 64'(g != 1));
      chk("wb_retry", 64'(wb_retry), 64'(g != 2));
      chk("pfreq_retry", 64'(pfreq_retry), 64'd0);

      // advance the model by one clock
      if (m_full && !mem_retry) m_full = 1'b0;
      if (g != 0) begin
        m_full = 1'b1;
        m_drid = '0; m_cmd = '0; m_nid = '0; m_line = '0;
        case (g)
          1: begin m_kind = 2'd0; m_drid = req_drid; m_cmd = req_cmd; m_paddr = req_paddr; end
          2: begin m_kind = 2'd1; m_paddr = wb_paddr; m_line = wb_line; end
          default: begin m_kind = 2'd2; m_nid = pfq[0].nid; m_paddr = pfq[0].paddr; end
        endcase
      end
      if (!wb_valid || g == 2) m_wb_age = 0;
      else if (m_wb_age < 15) m_wb_age++;

      pop = (pfq.size() > 0) && (g == 3 || !pfq[0].v);
      dropped = 1'b0;
      if (g == 1) begin
        foreach (pfq[i]) if (line_of(pfq[i].paddr) == line_of(req_paddr)) pfq[i].v = 1'b0;
      end
      if (pop) void'(pfq.pop_front());
      if (pfreq_valid) begin
        if (pfq.size() == PF_DEPTH) begin
          void'(pfq.pop_front());
          dropped = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        e.v     = !(g == 1 && line_of(pfreq_paddr) == line_of(req_paddr));
        e.nid   = pfreq_nid;
        e.paddr = pfreq_paddr;
        pfq.push_back(e);
      end
      if (pop || dropped) m_pf_age = 0;
      else if (head_v && g != 3 && m_pf_age < 31) m_pf_age++;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int drid, input int cmd, input logic [PADDR_W-1:0] a);
    req_valid = 1'b1; req_drid = DRID_W'(drid); req_cmd = CMD_W'(cmd); req_paddr = a;
  endtask

  task automatic drive_wb(input logic [PADDR_W-1:0] a, input logic [LINE_W-1:0] l);
    wb_valid = 1'b1; wb_paddr = a; wb_line = l;
  endtask

  task automatic drive_pf(input int nid, input logic [PADDR_W-1:0] a);
    pfreq_valid = 1'b1; pfreq_nid = NID_W'(nid); pfreq_paddr = a;
  endtask

  function automatic logic [PADDR_W-1:0] raddr();
    return 50'h20000 + 50'($urandom_range(0, 5)) * 50'd64 + 50'($urandom_range(0, 63));
  endfunction

  function automatic logic [LINE_W-1:0] rline();
    logic [LINE_W-1:0] l;
    for (int j = 0; j < LINE_W / 32; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  logic [LINE_W-1:0] l1, l2, l3, l4;
  bit ra, wa;
  int hi_window;

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    req_valid = 0; req_drid = '0; req_cmd = '0; req_paddr = '0;
    wb_valid = 0; wb_line = '0; wb_paddr = '0;
    pfreq_valid = 0; pfreq_nid = '0; pfreq_paddr = '0;
    mem_retry = 0;
    l1 = rline(); l2 = rline(); l3 = rline(); l4 = rline();

    // reset holds retries high even with traffic offered
    repeat (3) step();
    drive_req(1, 1, 50'h100);
    drive_wb(50'h100, l1);
    #1;
    chk("lit_rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("lit_rst_req_retry", 64'(req_retry), 64'd1);
    chk("lit_rst_wb_retry", 64'(wb_retry), 64'd1);
    chk("lit_rst_drop", 64'(pf_drop_cnt), 64'd0);
    req_valid = 0; wb_valid = 0;
    step();
    reset = 1'b1;
    step(); step();

    // single demand request, 1-cycle latency
    drive_req(5, 1, 50'h1000);
    #1 chk("lit_t1_req_retry", 64'(req_retry), 64'd0);
    step();
    req_valid = 0;
    chk("lit_t1_valid", 64'(mem_valid), 64'd1);
    chk("lit_t1_kind", 64'(mem_kind), 64'd0);
    chk("lit_t1_drid", 64'(mem_drid), 64'd5);
    chk("lit_t1_cmd", 64'(mem_cmd), 64'd1);
    chk("lit_t1_paddr", 64'(mem_paddr), 64'h1000);
    step();

    // same-line req and wb: wb first
    drive_req(6, 2, 50'h2040);
    drive_wb(50'h2040, l1);
    #1;
    chk("lit_t2_req_retry", 64'(req_retry), 64'd1);
    chk("lit_t2_wb_retry", 64'(wb_retry), 64'd0);
    step();
    wb_valid = 0;
    #1;
    chk("lit_t2_kind_wb", 64'(mem_kind), 64'd1);
    chk("lit_t2_paddr_wb", 64'(mem_paddr), 64'h2040);
    chk_line("lit_t2_line", mem_line, l1);
    chk("lit_t2_req_retry2", 64'(req_retry), 64'd0);
    step();
    req_valid = 0;
    chk("lit_t2_kind_req", 64'(mem_kind), 64'd0);
    chk("lit_t2_drid", 64'(mem_drid), 64'd6);

    // different lines: req first
    drive_req(7, 3, 50'h2040);
    drive_wb(50'h3000, l2);
    #1;
    chk("lit_t2b_req_retry", 64'(req_retry), 64'd0);
    chk("lit_t2b_wb_retry", 64'(wb_retry), 64'd1);
    step();
    req_valid = 0;
    #1;
    chk("lit_t2b_kind_req", 64'(mem_kind), 64'd0);
    chk("lit_t2b_drid", 64'(mem_drid), 64'd7);
    chk("lit_t2b_wb_retry2", 64'(wb_retry), 64'd0);
    step();
    wb_valid = 0;
    chk("lit_t2b_kind_wb", 64'(mem_kind), 64'd1);
    chk("lit_t2b_paddr_wb", 64'(mem_paddr), 64'h3000);
    chk_line("lit_t2b_line", mem_line, l2);
    step();

    // backpressure: output held stable, both retries high
    drive_req(8, 0, 50'h5000);
    step();
    drive_req(9, 4, 50'h6000);
    drive_wb(50'h7000, l3);
    mem_retry = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lit_t3_hold_valid", 64'(mem_valid), 64'd1);
      chk("lit_t3_hold_drid", 64'(mem_drid), 64'd8);
      chk("lit_t3_hold_paddr", 64'(mem_paddr), 64'h5000);
      chk("lit_t3_req_retry", 64'(req_retry), 64'd1);
      chk("lit_t3_wb_retry", 64'(wb_retry), 64'd1);
      step();
    end
    mem_retry = 0;
    #1 chk("lit_t3_rel_req_retry", 64'(req_retry), 64'd0);
    step();
    req_valid = 0;
    #1;
    chk("lit_t3_kind_req", 64'(mem_kind), 64'd0);
    chk("lit_t3_drid", 64'(mem_drid), 64'd9);
    step();
    wb_valid = 0;
    chk("lit_t3_valid_wb", 64'(mem_valid), 64'd1);
    chk("lit_t3_kind_wb", 64'(mem_kind), 64'd1);
    chk("lit_t3_paddr_wb", 64'(mem_paddr), 64'h7000);
    step();

    // prefetch overflow: 10 pushes into 8 entries while stalled
    drive_req(10, 0, 50'h9000);
    step();
    req_valid = 0;
    mem_retry = 1;
    for (int i = 1; i <= 10; i++) begin
      drive_pf(i, 50'h10000 + 50'(i) * 50'h40);
      step();
    end
    pfreq_valid = 0;
    chk("lit_t4_drop", 64'(pf_drop_cnt), 64'd2);
    chk("lit_t4_hold_drid", 64'(mem_drid), 64'd10);
    mem_retry = 0;
    step();
    chk("lit_t4_kind0", 64'(mem_kind), 64'd2);
    chk("lit_t4_nid0", 64'(mem_nid), 64'd3);
    chk("lit_t4_paddr0", 64'(mem_paddr), 64'h100C0);
    step();
    chk("lit_t4_nid1", 64'(mem_nid), 64'd4);
    chk("lit_t4_paddr1", 64'(mem_paddr), 64'h10100);
    repeat (8) step();

    // squash: queued and same-cycle prefetches to the granted req line vanish
    drive_req(11, 0, 50'h8000);
    step();
    req_valid = 0;
    mem_retry = 1;
    drive_pf(1, 50'h4000);
    step();
    drive_pf(2, 50'h4020);
    step();
    drive_pf(3, 50'h4030);
    drive_req(12, 5, 50'h4010);
    mem_retry = 0;
    #1 chk("lit_t5_req_retry", 64'(req_retry), 64'd0);
    step();
    req_valid = 0; pfreq_valid = 0;
    chk("lit_t5_kind", 64'(mem_kind), 64'd0);
    chk("lit_t5_drid", 64'(mem_drid), 64'd12);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("lit_t5_no_issue", 64'(mem_valid), 64'd0);
    end
    chk("lit_t5_drop", 64'(pf_drop_cnt), 64'd2);

    // prefetch starvation under continuous demand traffic
    drive_req(13, 1, 50'hB000);
    drive_pf(21, 50'hA000);
    for (int k = 0; k <= 17; k++) begin
      step();
      pfreq_valid = 0;
      chk("lit_t6_kind", 64'(mem_kind), (k == 17) ? 64'd2 : 64'd0);
    end
    chk("lit_t6_nid", 64'(mem_nid), 64'd21);
    chk("lit_t6_paddr", 64'(mem_paddr), 64'hA000);

    // writeback starvation under continuous demand traffic
    drive_wb(50'hC000, l4);
    for (int k = 0; k <= 4; k++) begin
      step();
      chk("lit_t6b_kind", 64'(mem_kind), (k == 4) ? 64'd1 : 64'd0);
    end
    wb_valid = 0;
    chk("lit_t6b_paddr", 64'(mem_paddr), 64'hC000);

    // asynchronous reset mid-stream
    step();
    #2 reset = 1'b0;
    #1;
    chk("lit_t7_valid", 64'(mem_valid), 64'd0);
    chk("lit_t7_req_retry", 64'(req_retry), 64'd1);
    chk("lit_t7_drop", 64'(pf_drop_cnt), 64'd0);
    step(); step();
    req_valid = 0;
    #2 reset = 1'b1;
    step();

    // random traffic obeying the hold-while-retried rule
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      ra = req_valid && !req_retry;
      wa = wb_valid && !wb_retry;
      @(posedge clk);
      #1;
      hi_window = ((c / 150) % 3 == 2) ? 90 : 30;
      if (!req_valid || ra) begin
        req_valid = ($urandom_range(0, 99) < 60);
        req_drid  = DRID_W'($urandom);
        req_cmd   = CMD_W'($urandom);
        req_paddr = raddr();
      end
      if (!wb_valid || wa) begin
        wb_valid = ($urandom_range(0, 99) < 40);
        wb_paddr = raddr();
        wb_line  = rline();
      end
      pfreq_valid = ($urandom_range(0, 99) < 30);
      pfreq_nid   = NID_W'($urandom);
      pfreq_paddr = raddr();
      mem_retry   = ($urandom_range(0, 99) < hi_window);
    end

    // drain
    @(posedge clk);
    #1;
    req_valid = 0; wb_valid = 0; pfreq_valid = 0; mem_retry = 0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dr_mem_sched.md
Name: dr_mem_sched

Overview:
Directory-bank memory-side scheduler. It merges three directory-to-memory streams onto one registered memory request channel: demand requests, writebacks, and L2 prefetches. Prefetches are held in a small drop-oldest queue. The block orders writebacks ahead of same-line demand reads, and uses age counters so that no stream starves. It sits between the directory bank pipeline and the memory controller port.

Parameters:
PADDR_W, 50, physical address width (bits [5:0] are the byte offset within the 64B line)
DRID_W, 6, directory request id width
CMD_W, 3, memory command width
NID_W, 5, node id width
LINE_W, 512, cache line width
PF_DEPTH, 8, prefetch queue entries (power of 2, minimum 2)
WB_STARVE, 4, wait cycles before a writeback is force-granted
PF_STARVE, 16, wait cycles before the prefetch head is force-granted

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  demand request valid
req_retry  out  1  demand request backpressure
req_drid  in  DRID_W  demand request id
req_cmd  in  CMD_W  demand command
req_paddr  in  PADDR_W  demand address
wb_valid  in  1  writeback valid
wb_retry  out  1  writeback backpressure
wb_line  in  LINE_W  writeback data
wb_paddr  in  PADDR_W  writeback address
pfreq_valid  in  1  prefetch valid
pfreq_retry  out  1  prefetch backpressure; constant 0
pfreq_nid  in  NID_W  prefetch node id
pfreq_paddr  in  PADDR_W  prefetch address
mem_valid  out  1  memory channel valid
mem_retry  in  1  memory channel backpressure
mem_kind  out  2  0=req, 1=wb, 2=pf
mem_drid  out  DRID_W  request id (req only, else 0)
mem_cmd  out  CMD_W  command (req only, else 0)
mem_nid  out  NID_W  node id (pf only, else 0)
mem_paddr  out  PADDR_W  address
mem_line  out  LINE_W  data (wb only, else 0)
pf_drop_cnt  out  16  count of dropped prefetches, saturating

Behaviour:
- Handshake: a transfer occurs when valid is high and retry is low in the same cycle. Payload must be held while valid is high and retry is high.
- Reset: while reset is low, all flops clear: mem_valid=0, all mem_* fields=0, pf_drop_cnt=0, queue empty, age counters=0. req_retry=1 and wb_retry=1 while reset is low.
- Output stage: one register holding either EMPTY or FULL.
  - A load is allowed when the register is EMPTY, or when it is FULL and draining this cycle (mem_valid and !mem_retry).
  - Latency from input acceptance to mem_valid is 1 cycle. Back-to-back issue runs at 1 per cycle.
- Grant priority, evaluated only in cycles where a load is allowed:
  1. wb, if wb_valid and wb_age>=WB_STARVE
  2. pf, if the head entry is valid and pf_age>=PF_STARVE
  3. req, if req_valid and NOT (wb_valid and wb_paddr[PADDR_W-1:6]==req_paddr[PADDR_W-1:6])
  4. wb, if wb_valid
  5. pf, if the head entry is valid
- req_retry = !(req granted); wb_retry = !(wb granted). Retries are combinational from state and mem_retry.
- wb_age (4 bits, saturating):
  - +1 each cycle wb_valid is high and wb is not granted.
  - Clears on a wb grant or when wb_valid is low.
- pf_age (5 bits, saturating):
  - +1 each cycle the head entry is valid and not granted.
  - Clears on a pf pop.
- Prefetch queue: circular buffer with head/tail pointers plus count. Each entry holds {valid, nid, paddr}.
  - Push: every cycle pfreq_valid=1.
  - Full with push and no pop in the same cycle: the head is discarded, head advances, the new entry is pushed, and pf_drop_cnt increments.
  - Full with push and pop in the same cycle: no drop.
  - Pointers wrap modulo PF_DEPTH.
- Squash: on a req grant, every queued entry whose line address matches req_paddr gets valid cleared.
  - An entry pushed in the same cycle with a matching line address is also squashed.
  - Squashes are not counted in pf_drop_cnt.
- Invalid head: if the head entry has valid=0 and count>0, it is popped silently that cycle (no grant, no drop count).
- pf grant: pops the head. Output kind=2, nid and paddr come from the entry.
- Simultaneous req and wb to the same line: wb is issued first, and req waits at least 1 cycle.
- A reset asserted mid-operation immediately clears the output register and the queue. In-flight content is lost.

Test Plan:
- Idle, then req_valid with drid=5, cmd=1, paddr=0x1000 → next cycle mem_valid=1, kind=0, drid=5, paddr=0x1000; req_retry=0 in the accept cycle.
- req and wb both valid, both with paddr=0x2040 (same line) → wb issued first (kind=1), then req next cycle; with wb paddr=0x3000 instead, req is issued first.
- mem_retry=1 held for 3 cycles with output FULL → mem_* fields stable, req_retry=wb_retry=1; release → drain then new load, 1 per cycle.
- PF_DEPTH=8: push 10 prefetches with mem_retry=1 → pf_drop_cnt=2; the first entries issued after release are the 3rd and 4th pushed.
- Queue holds pf paddr 0x4000 and 0x4020; req granted with paddr 0x4010 → both entries squashed, never issued, pf_drop_cnt unchanged.
- req_valid held continuously with one pf queued → pf issued on the 17th waiting cycle (PF_STARVE=16); wb waiting behind req force-granted after 4 cycles; reset low mid-stream → mem_valid=0 asynchronously.
